// File: rtl/board_read_arbiter.sv
// board_read_arbiter
// Shares the single read port of the board tile store between the video
// scan-out path (normally wins) and the matcher (latency tolerant, but
// guaranteed progress through a starvation counter). A tag pipeline that
// matches the board read latency marks each returned colour with the
// requester that issued the read.
module board_read_arbiter #(
    parameter int READ_LAT = 1,   // board read latency, 1..4
    parameter int MAX_WAIT = 8    // denied matcher cycles before forced priority, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    // video scan-out requester
    input  logic       vid_req,
    input  logic [5:0] vid_addr,
    output logic       vid_gnt,
    output logic       vid_valid,
    // matcher requester
    input  logic       mt_req,
    input  logic [5:0] mt_addr,
    output logic       mt_gnt,
    output logic       mt_valid,
    // board read port
    output logic [5:0] brd_addr,
    input  logic [2:0] brd_r,
    input  logic [2:0] brd_g,
    input  logic [1:0] brd_b,
    // shared return data
    output logic [2:0] rd_r,
    output logic [2:0] rd_g,
    output logic [1:0] rd_b,
    output logic       mt_starved
);

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [7:0]               wait_cnt;
    logic [5:0]               last_addr;
    logic [READ_LAT-1:0][1:0] tag_pipe;   // {vid, mt} per in-flight read
    logic                     starve_win;

    // Forced-priority window is a pure decode of the registered counter, so
    // the matcher is granted in the very cycle the count reaches the limit.
    assign starve_win = (wait_cnt == WAIT_MAX);
    assign mt_starved = starve_win & ~rst;

    // Grant selection and board address mux; nothing is granted in reset and
    // the address idles at the last granted value otherwise.
    always_comb begin
        vid_gnt  = 1'b0;
        mt_gnt   = 1'b0;
        brd_addr = last_addr;
        if (rst) begin
            brd_addr = 6'd0;
        end else if (starve_win && mt_req) begin
            mt_gnt   = 1'b1;
            brd_addr = mt_addr;
        end else if (vid_req) begin
            vid_gnt  = 1'b1;
            brd_addr = vid_addr;
        end else if (mt_req) begin
            mt_gnt   = 1'b1;
            brd_addr = mt_addr;
        end
    end

    // Starvation counter: counts consecutive denied matcher cycles, restarts
    // whenever the matcher is served or withdraws, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (!mt_req || mt_gnt) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Remember the last granted address so the board port is stable when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= 6'd0;
        end else if (vid_gnt || mt_gnt) begin
            last_addr <= brd_addr;
        end
    end

    // Tag pipeline: follows each grant down the board latency; reset drops
    // every in-flight tag so aborted reads never report valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= {vid_gnt, mt_gnt};
            for (int i = 1; i < READ_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign vid_valid = tag_pipe[READ_LAT-1][1] & ~rst;
    assign mt_valid  = tag_pipe[READ_LAT-1][0] & ~rst;

    // Return data is a straight pass-through; only the valid flags qualify it.
    assign rd_r = brd_r;
    assign rd_g = brd_g;
    assign rd_b = brd_b;

endmodule

// File: tb/tb_board_read_arbiter.sv
// Bench for board_read_arbiter: three instances (READ_LAT 1, 2, 3) share one
// stimulus stream. The stimulus pushes per-cycle grant expectations and
// per-read return expectations; one monitor pops and compares at negedge.
module tb_board_read_arbiter;

    localparam logic [1:0] NG = 2'b00;
    localparam logic [1:0] VG = 2'b10;
    localparam logic [1:0] MG = 2'b01;

    typedef struct {
        logic [1:0] gnt;
        logic [5:0] addr;
        logic       st;
    } cyc_exp_t;

    typedef struct {
        logic [1:0] who;
        logic [5:0] addr;
        int         due;
    } rd_exp_t;

    logic clk = 1'b1;
    logic rst, vid_req, mt_req;
    logic [5:0] vid_addr, mt_addr;

    logic [2:0] vid_gnt, mt_gnt, vid_valid, mt_valid, mt_starved;
    logic [5:0] brd_addr [3];
    logic [2:0] brd_r [3], brd_g [3], rd_r [3], rd_g [3];
    logic [1:0] brd_b [3], rd_b [3];

    cyc_exp_t cyc_q[$];
    rd_exp_t  vq[3][$];
    int       cyc_cnt = 0;
    int       n_vec = 0;
    int       n_bad = 0;
    logic     done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Colour stored in each board tile (bench-defined board contents).
    function automatic logic [7:0] tile_col(input logic [5:0] a);
        return {a[2:0], a[5:3], a[1:0] ^ 2'b10};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int L = gi + 1;
        logic [5:0] apipe [L];

        board_read_arbiter #(.READ_LAT(L), .MAX_WAIT(8)) u_dut (
            .clk(clk), .rst(rst),
            .vid_req(vid_req), .vid_addr(vid_addr),
            .vid_gnt(vid_gnt[gi]), .vid_valid(vid_valid[gi]),
            .mt_req(mt_req), .mt_addr(mt_addr),
            .mt_gnt(mt_gnt[gi]), .mt_valid(mt_valid[gi]),
            .brd_addr(brd_addr[gi]),
            .brd_r(brd_r[gi]), .brd_g(brd_g[gi]), .brd_b(brd_b[gi]),
            .rd_r(rd_r[gi]), .rd_g(rd_g[gi]), .rd_b(rd_b[gi]),
            .mt_starved(mt_starved[gi])
        );

        // Board model: address sampled each cycle, data L cycles later.
        always @(posedge clk) begin
            apipe[0] <= brd_addr[gi];
            for (int j = 1; j < L; j++) apipe[j] <= apipe[j-1];
        end
        assign {brd_r[gi], brd_g[gi], brd_b[gi]} = tile_col(apipe[L-1]);
    end

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s lat%0d cyc %0d: got %0h want %0h", name, k + 1, cyc_cnt, act, exp);
        end
    endtask

    // One cycle of stimulus plus the expectations it implies.
    task automatic step(input logic r, input logic vr, input logic [5:0] va,
                        input logic mr, input logic [5:0] ma,
                        input logic [1:0] eg, input logic [5:0] ea, input logic es,
                        input logic trk = 1'b1);
        cyc_exp_t ce;
        rd_exp_t  re;
        rst = r; vid_req = vr; vid_addr = va; mt_req = mr; mt_addr = ma;
        ce.gnt = eg; ce.addr = ea; ce.st = es;
        cyc_q.push_back(ce);
        if (trk && eg != NG) begin
            for (int k = 0; k < 3; k++) begin
                re.who = eg; re.addr = ea; re.due = cyc_cnt + k + 1;
                vq[k].push_back(re);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [5:0] ea);
        for (int i = 0; i < n; i++) step(0, 0, 6'd0, 0, 6'd0, NG, ea, 0);
    endtask

    // Monitor: compares grants, address, starvation and returns every cycle.
    always @(negedge clk) begin
        cyc_exp_t ce;
        rd_exp_t  re;
        logic [1:0] ev;
        if (cyc_q.size() != 0) begin
            ce = cyc_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk("gnt", k, int'({vid_gnt[k], mt_gnt[k]}), int'(ce.gnt));
                chk("brd_addr", k, int'(brd_addr[k]), int'(ce.addr));
                chk("starved", k, int'(mt_starved[k]), int'(ce.st));
                ev = NG;
                if (vq[k].size() != 0 && vq[k][0].due == cyc_cnt) begin
                    re = vq[k].pop_front();
                    ev = re.who;
                    chk("rd", k, int'({rd_r[k], rd_g[k], rd_b[k]}), int'(tile_col(re.addr)));
                end
                chk("valid", k, int'({vid_valid[k], mt_valid[k]}), int'(ev));
            end
        end else if (done) begin
            for (int k = 0; k < 3; k++) chk("drain", k, vq[k].size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of run, want done");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        // Reset with both requesting: nothing granted, address 0.
        step(1, 1, 6'd7, 1, 6'd9, NG, 6'd0, 0);
        step(1, 1, 6'd7, 1, 6'd9, NG, 6'd0, 0);

        // Matcher alone, tile 5.
        step(0, 0, 6'd0, 1, 6'd5, MG, 6'd5, 0);
        idle(3, 6'd5);

        // Both continuous: 8 video grants, then forced matcher grant, repeat.
        v = 0;
        for (int k = 0; k < 18; k++) begin
            if (k % 9 == 8) step(0, 1, 6'(v), 1, 6'd12, MG, 6'd12, 1);
            else begin
                step(0, 1, 6'(v), 1, 6'd12, VG, 6'(v), 0);
                v++;
            end
        end
        idle(1, 6'd12);

        // Alternating single requesters, back to back.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) step(0, 1, 6'(20 + k), 0, 6'd0, VG, 6'(20 + k), 0);
            else            step(0, 0, 6'd0, 1, 6'(20 + k), MG, 6'(20 + k), 0);
        end
        idle(3, 6'd25);

        // Matcher withdraws after 5 denials; counter restarts from zero.
        for (int k = 0; k < 14; k++)
            step(0, 1, 6'(48 + k), (k != 5), 6'd40, VG, 6'(48 + k), 0);
        step(0, 1, 6'd62, 1, 6'd40, MG, 6'd40, 1);
        idle(1, 6'd40);

        // Idle after a grant of 33 holds the address.
        step(0, 0, 6'd0, 1, 6'd33, MG, 6'd33, 0);
        idle(6, 6'd33);

        // Reset right after a matcher grant: the read is dropped.
        step(0, 0, 6'd0, 1, 6'd17, MG, 6'd17, 0, 1'b0);
        step(1, 1, 6'd3, 1, 6'd17, NG, 6'd0, 0);
        step(1, 1, 6'd3, 1, 6'd17, NG, 6'd0, 0);
        idle(4, 6'd0);

        done = 1'b1;
    end

endmodule

// File: doc/board_read_arbiter.md
# board_read_arbiter

Shares the single read port of the `board` tile store between two requesters: the video scan-out path, which has hard real-time needs, and the `matcher`, which is latency-tolerant. The block sits between both requesters and `board`. It drives the board address, grants one request per cycle, and tracks in-flight reads so each returned colour is flagged to the requester that issued it. Video normally wins; a starvation counter guarantees the matcher forward progress.

## Interface
Parameters:
- `READ_LAT`, 1: board read latency in cycles (address presented in cycle N → data valid in cycle N+READ_LAT); legal 1–4.
- `MAX_WAIT`, 8: consecutive cycles of denied matcher request before the matcher gets forced priority; legal 1–255.

Ports:
- `clk`, in, 1: system clock; all state on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `vid_req`, in, 1: video read request.
- `vid_addr`, in, 6: video tile address (0–35 used).
- `vid_gnt`, out, 1: video request accepted this cycle.
- `vid_valid`, out, 1: `rd_r/g/b` carries video data this cycle.
- `mt_req`, in, 1: matcher read request.
- `mt_addr`, in, 6: matcher tile address.
- `mt_gnt`, out, 1: matcher request accepted this cycle.
- `mt_valid`, out, 1: `rd_r/g/b` carries matcher data this cycle.
- `brd_addr`, out, 6: address to `board`.
- `brd_r` / `brd_g` / `brd_b`, in, 3/3/2: board read data.
- `rd_r` / `rd_g` / `rd_b`, out, 3/3/2: shared return data (pass-through of `brd_*`).
- `mt_starved`, out, 1: forced-priority window is active.

## Operation
- Requesters hold `*_req` and `*_addr` stable until they see `*_gnt`. Dropping a request before grant is legal; the request is withdrawn.
- Grant is combinational from the current requests and registered state. At most one grant is high per cycle.
- Priority:
  - If `mt_starved` = 1 and `mt_req` = 1: the matcher is granted.
  - Otherwise, if `vid_req` = 1: video is granted.
  - Otherwise, if `mt_req` = 1: the matcher is granted.
- `brd_addr` equals the granted requester's address. With no grant, `brd_addr` holds the last granted address (register `last_addr`, reset 0).
- Starvation counter `wait_cnt` (8 bit):
  - Cleared on reset and on any `mt_gnt`.
  - Cleared when `mt_req` = 0.
  - Incremented when `mt_req` = 1 and `mt_gnt` = 0.
  - Saturates at `MAX_WAIT`.
- `mt_starved` = (`wait_cnt` == `MAX_WAIT`), registered.
- Tag pipeline: a `READ_LAT`-deep shift register of 2-bit tags {vid, mt}, shifting every cycle.
  - Stage 0 is loaded with {`vid_gnt`, `mt_gnt`}.
  - `vid_valid` and `mt_valid` are the final stage.
- `rd_*` = `brd_*` at all times. Only the valid flags qualify the data.
- Reset value of every output:
  - `vid_gnt`, `mt_gnt`, `vid_valid`, `mt_valid`, `mt_starved` = 0.
  - `brd_addr` = 0.
  - `rd_*` follows `brd_*`.

## Timing
- Request accepted in cycle N: `*_gnt` = 1 in cycle N, and exactly one `*_valid` pulse in cycle N+READ_LAT.
- Throughput: one read per cycle, back-to-back, any requester mix.
- Continuous `vid_req` with `mt_req` = 1 from cycle N:
  - `wait_cnt` reaches `MAX_WAIT` at the edge ending cycle N+MAX_WAIT−1.
  - `mt_starved` = 1 in cycle N+MAX_WAIT, and `mt_gnt` = 1 in that same cycle.
  - `mt_starved` falls in the next cycle.
  - The worst-case matcher wait is therefore `MAX_WAIT` cycles.
- Simultaneous requests with no starvation: video is granted and the matcher waits. Neither request is lost.
- Reset mid-operation: the tag pipeline clears, so in-flight reads produce no `*_valid`. Requesters must reissue.
- Address wrap: `*_addr` values 36–63 are forwarded unchanged. Range checking is the board's responsibility.

## Test plan
1. Reset, then matcher only: `mt_req`=1 with `mt_addr`=5 for 1 cycle.
   - Required: `mt_gnt`=1 and `brd_addr`=5 in the same cycle.
   - Required: `mt_valid`=1 one cycle later (`READ_LAT`=1), with `rd_*` equal to board tile 5 colour. `vid_valid` never asserts.
2. Both requesting continuously, `MAX_WAIT`=8, `vid_addr`=0..35 incrementing, `mt_addr`=12.
   - Required: `vid_gnt` for 8 cycles, then `mt_gnt`=1 with `brd_addr`=12 in the 9th cycle.
   - Required: video resumes in the following cycle and the pattern repeats every 9 cycles.
3. Back-to-back alternating grants with `READ_LAT`=3.
   - Required: the valid pulses reproduce the grant sequence delayed exactly 3 cycles, never both valid in one cycle.
4. `rst` asserted 1 cycle after a `mt_gnt` with `READ_LAT`=2.
   - Required: no `mt_valid` appears.
   - Required: all outputs are 0 (except `rd_*`) during reset, and `brd_addr`=0 after release.
5. Matcher drops `mt_req` after 5 denied cycles, then reasserts.
   - Required: `wait_cnt` cleared, so 8 further denied cycles elapse before the forced grant.
6. Idle after a grant of address 33.
   - Required: `brd_addr` holds 33, with no grants and no valids.
